// File: rtl/sparc_mul_req_arb.sv
// sparc_mul_req_arb: issue stage in front of the SPARC multiplier.
// It buffers one EXU multiply request and one SPU request (MAC, bypass or
// accumulator shift). It arbitrates between them round-robin, issues one op at a
// time as a single-cycle pulse, and holds the op until the matching ack returns.
// If that ack does not arrive within ACK_TIMEOUT wait cycles, it sets a sticky
// error and frees the slot.
//
// Ports:
//   rclk, arst_l                   clock, async active-low reset
//   exu_req_vld/rdy/rs1/rs2        EXU request handshake and operands
//   spu_req_vld/rdy/op1/op2        SPU request handshake and operands
//   spu_req_acc/shf/rst            SPU qualifiers (MAC, shift op, accumulator reset)
//   exu_mul_input_vld, *_rs*_data  EXU issue pulse and operands to the multiplier
//   spu_mul_req_vld/areg_shf       SPU issue pulses (MAC/bypass, shift)
//   spu_mul_acc/areg_rst/op*_data  SPU qualifiers and operands to the multiplier
//   mul_exu_ack/spu_ack/spu_shf_ack  acks from the multiplier
//   arb_busy                       an op is outstanding at the multiplier
//   arb_timeout_err                sticky ack-timeout flag
module sparc_mul_req_arb #(
    parameter int unsigned ACK_TIMEOUT = 64,
    parameter int unsigned CNT_W       = 8
) (
    input  logic        rclk,
    input  logic        arst_l,
    input  logic        exu_req_vld,
    output logic        exu_req_rdy,
    input  logic [63:0] exu_req_rs1,
    input  logic [63:0] exu_req_rs2,
    input  logic        spu_req_vld,
    output logic        spu_req_rdy,
    input  logic [63:0] spu_req_op1,
    input  logic [63:0] spu_req_op2,
    input  logic        spu_req_acc,
    input  logic        spu_req_shf,
    input  logic        spu_req_rst,
    output logic        exu_mul_input_vld,
    output logic [63:0] exu_mul_rs1_data,
    output logic [63:0] exu_mul_rs2_data,
    output logic        spu_mul_req_vld,
    output logic        spu_mul_areg_shf,
    output logic        spu_mul_acc,
    output logic        spu_mul_areg_rst,
    output logic [63:0] spu_mul_op1_data,
    output logic [63:0] spu_mul_op2_data,
    input  logic        mul_exu_ack,
    input  logic        mul_spu_ack,
    input  logic        mul_spu_shf_ack,
    output logic        arb_busy,
    output logic        arb_timeout_err
);

    typedef enum logic [1:0] {StIdle, StExuWait, StSpuWait, StShfWait} state_e;

    state_e             state_q, state_d;
    logic               rr_q, rr_d;       // 0: favour EXU, 1: favour SPU
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_q, err_d;

    logic               exu_full_q, exu_full_d;
    logic [63:0]        exu_rs1_q, exu_rs2_q;
    logic               spu_full_q, spu_full_d;
    logic [63:0]        spu_op1_q, spu_op2_q;
    logic               spu_acc_q, spu_shf_q, spu_rst_q;

    logic               exu_take, spu_take;
    logic               exu_free, spu_free;
    logic               issue_exu, issue_spu;
    logic               timeout_hit;

    assign exu_take = exu_req_vld & ~exu_full_q;
    assign spu_take = spu_req_vld & ~spu_full_q;

    // Issue only from IDLE, so an ack coincident with the issue pulse is never seen.
    assign issue_exu = (state_q == StIdle) & exu_full_q & (~spu_full_q | ~rr_q);
    assign issue_spu = (state_q == StIdle) & spu_full_q & (~exu_full_q | rr_q);

    // Counter holds k-1 in the k-th wait cycle; this is the cycle the count reaches
    // ACK_TIMEOUT, and an ack in the same cycle still takes priority.
    assign timeout_hit = (cnt_q == CNT_W'(ACK_TIMEOUT - 1));

    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        err_d    = err_q;
        exu_free = 1'b0;
        spu_free = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (issue_exu) begin
                    state_d = StExuWait;
                    cnt_d   = '0;
                    if (spu_full_q) rr_d = 1'b1;
                end else if (issue_spu) begin
                    state_d = spu_shf_q ? StShfWait : StSpuWait;
                    cnt_d   = '0;
                    if (exu_full_q) rr_d = 1'b0;
                end
            end
            StExuWait: begin
                if (mul_exu_ack || timeout_hit) begin
                    state_d  = StIdle;
                    exu_free = 1'b1;
                    if (!mul_exu_ack) err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StSpuWait: begin
                if (mul_spu_ack || timeout_hit) begin
                    state_d  = StIdle;
                    spu_free = 1'b1;
                    if (!mul_spu_ack) err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            StShfWait: begin
                if (mul_spu_shf_ack || timeout_hit) begin
                    state_d  = StIdle;
                    spu_free = 1'b1;
                    if (!mul_spu_shf_ack) err_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Capture and free never coincide on one slot: capture needs rdy=1, free needs full.
    assign exu_full_d = exu_take | (exu_full_q & ~exu_free);
    assign spu_full_d = spu_take | (spu_full_q & ~spu_free);

    always_ff @(posedge rclk or negedge arst_l) begin
        if (!arst_l) begin
            state_q    <= StIdle;
            rr_q       <= 1'b0;
            cnt_q      <= '0;
            err_q      <= 1'b0;
            exu_full_q <= 1'b0;
            exu_rs1_q  <= '0;
            exu_rs2_q  <= '0;
            spu_full_q <= 1'b0;
            spu_op1_q  <= '0;
            spu_op2_q  <= '0;
            spu_acc_q  <= 1'b0;
            spu_shf_q  <= 1'b0;
            spu_rst_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_q       <= rr_d;
            cnt_q      <= cnt_d;
            err_q      <= err_d;
            exu_full_q <= exu_full_d;
            spu_full_q <= spu_full_d;
            if (exu_take) begin
                exu_rs1_q <= exu_req_rs1;
                exu_rs2_q <= exu_req_rs2;
            end
            if (spu_take) begin
                spu_op1_q <= spu_req_op1;
                spu_op2_q <= spu_req_op2;
                spu_acc_q <= spu_req_acc;
                spu_shf_q <= spu_req_shf;
                spu_rst_q <= spu_req_rst;
            end
        end
    end

    assign exu_req_rdy       = ~exu_full_q;
    assign spu_req_rdy       = ~spu_full_q;
    assign exu_mul_input_vld = issue_exu;
    assign spu_mul_req_vld   = issue_spu & ~spu_shf_q;
    assign spu_mul_areg_shf  = issue_spu & spu_shf_q;
    // Slots cannot be overwritten while full, so these stay stable until the ack.
    assign exu_mul_rs1_data  = exu_rs1_q;
    assign exu_mul_rs2_data  = exu_rs2_q;
    assign spu_mul_op1_data  = spu_op1_q;
    assign spu_mul_op2_data  = spu_op2_q;
    assign spu_mul_acc       = spu_acc_q;
    assign spu_mul_areg_rst  = spu_rst_q;
    assign arb_busy          = (state_q != StIdle);
    assign arb_timeout_err   = err_q;

endmodule

// File: tb/tb_sparc_mul_req_arb.sv
module tb_sparc_mul_req_arb;

    logic        rclk = 1'b0;
    logic        arst_l;
    logic        exu_req_vld, exu_req_rdy;
    logic [63:0] exu_req_rs1, exu_req_rs2;
    logic        spu_req_vld, spu_req_rdy;
    logic [63:0] spu_req_op1, spu_req_op2;
    logic        spu_req_acc, spu_req_shf, spu_req_rst;
    logic        exu_mul_input_vld;
    logic [63:0] exu_mul_rs1_data, exu_mul_rs2_data;
    logic        spu_mul_req_vld, spu_mul_areg_shf, spu_mul_acc, spu_mul_areg_rst;
    logic [63:0] spu_mul_op1_data, spu_mul_op2_data;
    logic        mul_exu_ack, mul_spu_ack, mul_spu_shf_ack;
    logic        arb_busy, arb_timeout_err;

    int pass_cnt = 0;
    int total_cnt = 0;

    always #5 rclk = ~rclk;

    sparc_mul_req_arb #(.ACK_TIMEOUT(8), .CNT_W(8)) dut (
        .rclk              (rclk),
        .arst_l            (arst_l),
        .exu_req_vld       (exu_req_vld),
        .exu_req_rdy       (exu_req_rdy),
        .exu_req_rs1       (exu_req_rs1),
        .exu_req_rs2       (exu_req_rs2),
        .spu_req_vld       (spu_req_vld),
        .spu_req_rdy       (spu_req_rdy),
        .spu_req_op1       (spu_req_op1),
        .spu_req_op2       (spu_req_op2),
        .spu_req_acc       (spu_req_acc),
        .spu_req_shf       (spu_req_shf),
        .spu_req_rst       (spu_req_rst),
        .exu_mul_input_vld (exu_mul_input_vld),
        .exu_mul_rs1_data  (exu_mul_rs1_data),
        .exu_mul_rs2_data  (exu_mul_rs2_data),
        .spu_mul_req_vld   (spu_mul_req_vld),
        .spu_mul_areg_shf  (spu_mul_areg_shf),
        .spu_mul_acc       (spu_mul_acc),
        .spu_mul_areg_rst  (spu_mul_areg_rst),
        .spu_mul_op1_data  (spu_mul_op1_data),
        .spu_mul_op2_data  (spu_mul_op2_data),
        .mul_exu_ack       (mul_exu_ack),
        .mul_spu_ack       (mul_spu_ack),
        .mul_spu_shf_ack   (mul_spu_shf_ack),
        .arb_busy          (arb_busy),
        .arb_timeout_err   (arb_timeout_err)
    );

    typedef struct {
        logic        ev;
        logic [63:0] rs1, rs2;
        logic        sv;
        logic [63:0] op1;
        logic        acc, shf, rst, ea, sa, ha;
        logic        xp, sp, hp, busy, erdy, srdy;
        logic [63:0] xd1, xd2, sd1;
        logic        sacc, srst;
    } vec_t;

    vec_t tbl[27];

    function automatic vec_t mk(
        input logic ev, input logic [63:0] rs1, input logic [63:0] rs2,
        input logic sv, input logic [63:0] op1, input logic acc, input logic shf,
        input logic rst, input logic ea, input logic sa, input logic ha,
        input logic xp, input logic sp, input logic hp, input logic busy,
        input logic erdy, input logic srdy, input logic [63:0] xd1,
        input logic [63:0] xd2, input logic [63:0] sd1, input logic sacc,
        input logic srst);
        vec_t v;
        v.ev = ev; v.rs1 = rs1; v.rs2 = rs2; v.sv = sv; v.op1 = op1;
        v.acc = acc; v.shf = shf; v.rst = rst; v.ea = ea; v.sa = sa; v.ha = ha;
        v.xp = xp; v.sp = sp; v.hp = hp; v.busy = busy; v.erdy = erdy; v.srdy = srdy;
        v.xd1 = xd1; v.xd2 = xd2; v.sd1 = sd1; v.sacc = sacc; v.srst = srst;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h, expected %h", name, act, exp);
    endtask

    task automatic next_cycle();
        @(posedge rclk);
        #1;
    endtask

    task automatic clear_inputs();
        exu_req_vld = 0; exu_req_rs1 = '0; exu_req_rs2 = '0;
        spu_req_vld = 0; spu_req_op1 = '0; spu_req_op2 = '0;
        spu_req_acc = 0; spu_req_shf = 0; spu_req_rst = 0;
        mul_exu_ack = 0; mul_spu_ack = 0; mul_spu_shf_ack = 0;
    endtask

    // Issue one EXU op from IDLE; returns positioned in the first wait cycle.
    task automatic issue_exu_op(input string tag, input logic [63:0] rs1);
        exu_req_vld = 1; exu_req_rs1 = rs1; exu_req_rs2 = ~rs1;
        next_cycle();
        exu_req_vld = 0;
        @(negedge rclk);
        chk({tag, " issue pulse"}, exu_mul_input_vld, 1);
        chk({tag, " issue rs1"}, exu_mul_rs1_data, rs1);
        next_cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        clear_inputs();
        arst_l = 0;

        //                ev rs1    rs2    sv op1    acc shf rst ea sa ha  xp sp hp bz er sr  xd1    xd2    sd1    sacc srst
        tbl[0]  = mk(1, 64'h3, 64'h5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0);
        tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 3, 5, 0, 0, 0);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 5, 0, 0, 0);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 1, 3, 5, 0, 0, 0);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 0, 1, 3, 5, 0, 0, 0);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 3, 5, 0, 0, 0);
        tbl[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 3, 5, 0, 0, 0);
        tbl[7]  = mk(1, 64'h11, 64'h22, 1, 64'hAA, 1, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 1, 1, 3, 5, 0, 0, 0);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 'h11, 'h22, 'hAA, 1, 0);
        tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h11, 'h22, 'hAA, 1, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 'h11, 'h22, 'hAA, 1, 0);
        tbl[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 'h11, 'h22, 'hAA, 1, 0);
        tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h11, 'h22, 'hAA, 1, 0);
        tbl[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 'h11, 'h22, 'hAA, 1, 0);
        tbl[14] = mk(1, 64'h33, 64'h44, 1, 64'hCC, 0, 0, 0, 0, 0, 0,
                     0, 0, 0, 0, 1, 1, 'h11, 'h22, 'hAA, 1, 0);
        tbl[15] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 'h33, 'h44, 'hCC, 0, 0);
        tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 'h33, 'h44, 'hCC, 0, 0);
        tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 'h33, 'h44, 'hCC, 0, 0);
        tbl[18] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 'h33, 'h44, 'hCC, 0, 0);
        tbl[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 'h33, 'h44, 'hCC, 0, 0);
        tbl[20] = mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 'h33, 'h44, 'hCC, 0, 0);
        tbl[21] = mk(0, 0, 0, 1, 64'h77, 0, 1, 1, 0, 0, 0,
                     0, 0, 0, 0, 1, 1, 'h33, 'h44, 'hCC, 0, 0);
        // Shift ack coincident with the issue pulse must be ignored.
        tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 1, 0, 'h33, 'h44, 'h77, 0, 1);
        tbl[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 'h33, 'h44, 'h77, 0, 1);
        tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 1, 1, 0, 'h33, 'h44, 'h77, 0, 1);
        tbl[25] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 1, 1, 0, 'h33, 'h44, 'h77, 0, 1);
        tbl[26] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 'h33, 'h44, 'h77, 0, 1);

        // Reset state
        repeat (2) @(negedge rclk);
        chk("reset exu_rdy", exu_req_rdy, 1);
        chk("reset spu_rdy", spu_req_rdy, 1);
        chk("reset busy", arb_busy, 0);
        chk("reset err", arb_timeout_err, 0);
        chk("reset exu pulse", exu_mul_input_vld, 0);
        chk("reset exu data", exu_mul_rs1_data, 0);
        chk("reset spu data", spu_mul_op2_data, 0);
        arst_l = 1;
        next_cycle();

        for (int i = 0; i < 27; i++) begin
            exu_req_vld = tbl[i].ev; exu_req_rs1 = tbl[i].rs1; exu_req_rs2 = tbl[i].rs2;
            spu_req_vld = tbl[i].sv; spu_req_op1 = tbl[i].op1; spu_req_op2 = ~tbl[i].op1;
            spu_req_acc = tbl[i].acc; spu_req_shf = tbl[i].shf; spu_req_rst = tbl[i].rst;
            mul_exu_ack = tbl[i].ea; mul_spu_ack = tbl[i].sa; mul_spu_shf_ack = tbl[i].ha;
            @(negedge rclk);
            chk($sformatf("v%0d exu_pulse", i), exu_mul_input_vld, tbl[i].xp);
            chk($sformatf("v%0d spu_pulse", i), spu_mul_req_vld, tbl[i].sp);
            chk($sformatf("v%0d shf_pulse", i), spu_mul_areg_shf, tbl[i].hp);
            chk($sformatf("v%0d busy", i), arb_busy, tbl[i].busy);
            chk($sformatf("v%0d exu_rdy", i), exu_req_rdy, tbl[i].erdy);
            chk($sformatf("v%0d spu_rdy", i), spu_req_rdy, tbl[i].srdy);
            chk($sformatf("v%0d exu_rs1", i), exu_mul_rs1_data, tbl[i].xd1);
            chk($sformatf("v%0d exu_rs2", i), exu_mul_rs2_data, tbl[i].xd2);
            chk($sformatf("v%0d spu_op1", i), spu_mul_op1_data, tbl[i].sd1);
            chk($sformatf("v%0d spu_acc", i), spu_mul_acc, tbl[i].sacc);
            chk($sformatf("v%0d spu_rst", i), spu_mul_areg_rst, tbl[i].srst);
            chk($sformatf("v%0d err", i), arb_timeout_err, 0);
            next_cycle();
        end
        clear_inputs();

        // Ack in the last legal wait cycle (count reaches 8): no error
        issue_exu_op("ack8", 64'hA1);
        for (int k = 1; k <= 8; k++) begin
            mul_exu_ack = (k == 8);
            @(negedge rclk);
            chk($sformatf("ack8 busy k%0d", k), arb_busy, 1);
            next_cycle();
        end
        mul_exu_ack = 0;
        @(negedge rclk);
        chk("ack8 err", arb_timeout_err, 0);
        chk("ack8 busy after", arb_busy, 0);
        chk("ack8 exu_rdy", exu_req_rdy, 1);
        next_cycle();

        // No ack: timeout after 8 wait cycles
        issue_exu_op("tmo", 64'hB1);
        for (int k = 1; k <= 8; k++) begin
            @(negedge rclk);
            chk($sformatf("tmo busy k%0d", k), arb_busy, 1);
            chk($sformatf("tmo err k%0d", k), arb_timeout_err, 0);
            next_cycle();
        end
        @(negedge rclk);
        chk("tmo err set", arb_timeout_err, 1);
        chk("tmo busy after", arb_busy, 0);
        chk("tmo exu_rdy", exu_req_rdy, 1);
        next_cycle();

        // Normal op after timeout; error stays sticky
        issue_exu_op("post", 64'hC3);
        @(negedge rclk);
        chk("post busy", arb_busy, 1);
        next_cycle();
        mul_exu_ack = 1;
        next_cycle();
        mul_exu_ack = 0;
        @(negedge rclk);
        chk("post busy after", arb_busy, 0);
        chk("post exu_rdy", exu_req_rdy, 1);
        chk("post err sticky", arb_timeout_err, 1);
        next_cycle();

        // Reset while in SPU_WAIT with the EXU slot full
        spu_req_vld = 1; spu_req_op1 = 64'h99; spu_req_op2 = 64'h98; spu_req_acc = 1;
        next_cycle();
        spu_req_vld = 0;
        exu_req_vld = 1; exu_req_rs1 = 64'hD1; exu_req_rs2 = 64'hD2;
        @(negedge rclk);
        chk("rst spu pulse", spu_mul_req_vld, 1);
        next_cycle();
        exu_req_vld = 0;
        @(negedge rclk);
        chk("rst pre busy", arb_busy, 1);
        chk("rst pre exu_rdy", exu_req_rdy, 0);
        #1 arst_l = 0;
        #1;
        chk("rst async busy", arb_busy, 0);
        chk("rst async exu_rdy", exu_req_rdy, 1);
        chk("rst async spu_rdy", spu_req_rdy, 1);
        chk("rst async err", arb_timeout_err, 0);
        chk("rst async acc", spu_mul_acc, 0);
        chk("rst async exu data", exu_mul_rs1_data, 0);
        chk("rst async spu data", spu_mul_op1_data, 0);
        @(negedge rclk);
        arst_l = 1;
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            @(negedge rclk);
            chk($sformatf("rst lost exu pulse c%0d", k), exu_mul_input_vld, 0);
            chk($sformatf("rst lost busy c%0d", k), arb_busy, 0);
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
